// File: rtl/rgb_ramp_engine.sv
// rgb_ramp_engine: parallel colour-ramp engine. Holds CHANNELS colour
// registers and steps them (add / sub / seek-to-target, saturating or
// wrapping) once every DIV clocks while running, pulsing done on completion.

// Per-channel next-value datapath. Purely combinational: given the current
// value, its target and the latched step controls, produce the value after
// one tick and whether that value sits at the completion goal for the mode.
module rgb_ramp_lane #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  ch,
  input  logic [WIDTH-1:0]  tgt,
  input  logic [1:0]        mode,
  input  logic              sat,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  nxt,
  output logic              goal
);
  localparam logic [1:0] M_ADD  = 2'b01;
  localparam logic [1:0] M_SUB  = 2'b10;
  localparam logic [1:0] M_SEEK = 2'b11;

  // One extra bit on every intermediate catches carry-out / borrow.
  logic [WIDTH:0] stp;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;
  logic [WIDTH:0] up_gap;
  logic [WIDTH:0] dn_gap;

  // Step arithmetic and mode select for one channel
  always_comb begin
    stp    = (step == '0) ? (WIDTH+1)'(1) : (WIDTH+1)'(step);
    sum    = {1'b0, ch} + stp;
    dif    = {1'b0, ch} - stp;
    up_gap = {1'b0, tgt} - {1'b0, ch};
    dn_gap = {1'b0, ch} - {1'b0, tgt};
    nxt    = ch;
    goal   = 1'b0;
    case (mode)
      M_ADD: begin
        nxt  = (sat && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
        goal = (nxt == '1);
      end
      M_SUB: begin
        nxt  = (sat && dif[WIDTH]) ? '0 : dif[WIDTH-1:0];
        goal = (nxt == '0);
      end
      M_SEEK: begin
        // Land exactly on the target when the remaining gap fits in one step.
        if (tgt > ch)      nxt = (up_gap <= stp) ? tgt : sum[WIDTH-1:0];
        else if (tgt < ch) nxt = (dn_gap <= stp) ? tgt : dif[WIDTH-1:0];
        else               nxt = tgt;
        goal = (nxt == tgt);
      end
      default: begin
        nxt  = ch;
        goal = 1'b0;
      end
    endcase
  end
endmodule

module rgb_ramp_engine #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int STEP_W   = 4,
  parameter int DIV      = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [CHANNELS*WIDTH-1:0] ch_in,
  input  logic [CHANNELS*WIDTH-1:0] target_in,
  input  logic                      start,
  input  logic                      stop,
  input  logic [1:0]                mode,
  input  logic                      sat,
  input  logic [STEP_W-1:0]         step,
  output logic [CHANNELS*WIDTH-1:0] ch_out,
  output logic                      busy,
  output logic                      done
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_SEEK = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                             state_q, state_d;
  logic [CHANNELS-1:0][WIDTH-1:0]     ch_q, ch_d;
  logic [CHANNELS-1:0][WIDTH-1:0]     tgt_q, tgt_d;
  logic [1:0]                         mode_q, mode_d;
  logic                               sat_q, sat_d;
  logic [STEP_W-1:0]                  step_q, step_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;

  logic [CHANNELS-1:0][WIDTH-1:0]     ch_in_a;
  logic [CHANNELS-1:0][WIDTH-1:0]     tgt_in_a;
  logic [CHANNELS-1:0][WIDTH-1:0]     lane_nxt;
  logic [CHANNELS-1:0]                lane_goal;
  logic                               tick;
  logic                               complete;

  assign ch_in_a  = ch_in;
  assign tgt_in_a = target_in;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    rgb_ramp_lane #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_lane (
      .ch   (ch_q[g]),
      .tgt  (tgt_q[g]),
      .mode (mode_q),
      .sat  (sat_q),
      .step (step_q),
      .nxt  (lane_nxt[g]),
      .goal (lane_goal[g])
    );
  end

  // Wrap add/sub has no goal: only saturating or seek ramps can complete.
  assign tick     = (cnt_q == CNT_MAX);
  assign complete = (&lane_goal) && ((mode_q == M_SEEK) || sat_q);

  // Next-state: load overrides everything, then the IDLE/RUN/DONE sequencing
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tgt_d   = tgt_q;
    mode_d  = mode_q;
    sat_d   = sat_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    if (load) begin
      ch_d    = ch_in_a;
      tgt_d   = tgt_in_a;
      cnt_d   = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (mode != M_HOLD)) begin
            state_d = S_RUN;
            mode_d  = mode;
            sat_d   = sat;
            step_d  = step;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          // stop wins over a coincident tick; values simply freeze.
          if (stop) begin
            state_d = S_IDLE;
          end else if (tick) begin
            cnt_d = '0;
            ch_d  = lane_nxt;
            if (complete) state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; reset clears asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      tgt_q   <= '0;
      mode_q  <= '0;
      sat_q   <= 1'b0;
      step_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      tgt_q   <= tgt_d;
      mode_q  <= mode_d;
      sat_q   <= sat_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ch_out = ch_q;
  assign busy   = busy_q;
  assign done   = done_q;
endmodule

// File: tb/tb_rgb_ramp_engine.sv
// Bench for rgb_ramp_engine: two instances (DIV=1 and DIV=3) share one
// stimulus stream; an integer-level model tracks both and is compared every
// cycle, with directed scenarios pinning literal values along the way.
module tb_rgb_ramp_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [23:0] ch_in = '0;
  logic [23:0] target_in = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mode = '0;
  logic        sat = 1'b0;
  logic [3:0]  step = '0;
  logic [23:0] ch1, ch3;
  logic        busy1, busy3, done1, done3;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  rgb_ramp_engine #(.WIDTH(8), .CHANNELS(3), .STEP_W(4), .DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .load(load), .ch_in(ch_in), .target_in(target_in),
    .start(start), .stop(stop), .mode(mode), .sat(sat), .step(step),
    .ch_out(ch1), .busy(busy1), .done(done1));

  rgb_ramp_engine #(.WIDTH(8), .CHANNELS(3), .STEP_W(4), .DIV(3)) u3 (
    .clk(clk), .rst_n(rst_n), .load(load), .ch_in(ch_in), .target_in(target_in),
    .start(start), .stop(stop), .mode(mode), .sat(sat), .step(step),
    .ch_out(ch3), .busy(busy3), .done(done3));

  // Model: index 0 = DIV 1 instance, index 1 = DIV 3 instance
  int m_ch   [2][3];
  int m_tgt  [2][3];
  int m_run  [2];
  int m_done [2];
  int m_mode [2];
  int m_sat  [2];
  int m_step [2];
  int m_cnt  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 3; c++) begin
        m_ch[i][c] = 0;
        m_tgt[i][c] = 0;
      end
      m_run[i] = 0; m_done[i] = 0; m_mode[i] = 0;
      m_sat[i] = 0; m_step[i] = 0; m_cnt[i] = 0;
    end
  endtask

  // Advance one instance's model by one clock edge using current inputs.
  task automatic model_edge(input int i, input int div);
    int v, d, s, fin;
    if (load) begin
      for (int c = 0; c < 3; c++) begin
        m_ch[i][c]  = int'(ch_in[c*8 +: 8]);
        m_tgt[i][c] = int'(target_in[c*8 +: 8]);
      end
      m_run[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
    end else if (m_done[i] != 0) begin
      m_done[i] = 0;
    end else if (m_run[i] == 0) begin
      if (start && mode != 2'b00) begin
        m_run[i] = 1; m_mode[i] = int'(mode); m_sat[i] = int'(sat);
        m_step[i] = int'(step); m_cnt[i] = 0;
      end
    end else if (stop) begin
      m_run[i] = 0;
    end else begin
      m_cnt[i]++;
      if (m_cnt[i] == div) begin
        m_cnt[i] = 0;
        s = (m_step[i] == 0) ? 1 : m_step[i];
        fin = 1;
        for (int c = 0; c < 3; c++) begin
          v = m_ch[i][c];
          case (m_mode[i])
            1: begin
              v = v + s;
              if (v > 255) v = (m_sat[i] != 0) ? 255 : v - 256;
              if (v != 255 || m_sat[i] == 0) fin = 0;
            end
            2: begin
              v = v - s;
              if (v < 0) v = (m_sat[i] != 0) ? 0 : v + 256;
              if (v != 0 || m_sat[i] == 0) fin = 0;
            end
            default: begin
              d = m_tgt[i][c] - v;
              if (d >= -s && d <= s) v = m_tgt[i][c];
              else if (d > 0)        v = v + s;
              else                   v = v - s;
              if (v != m_tgt[i][c]) fin = 0;
            end
          endcase
          m_ch[i][c] = v;
        end
        if (fin != 0) begin
          m_run[i] = 0;
          m_done[i] = 1;
        end
      end
    end
  endtask

  function automatic logic [23:0] m_vec(input int i);
    logic [23:0] r;
    for (int c = 0; c < 3; c++) r[c*8 +: 8] = 8'(m_ch[i][c]);
    return r;
  endfunction

  // One clock: model follows the edge, inputs may change 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_edge(0, 1);
      model_edge(1, 3);
    end
    #1;
  endtask

  task automatic do_load(input logic [23:0] c, input logic [23:0] t);
    load = 1'b1; ch_in = c; target_in = t;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] m, input logic s, input logic [3:0] st);
    start = 1'b1; mode = m; sat = s; step = st;
    tick();
    start = 1'b0;
  endtask

  // Every-cycle comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cmp_en) begin
        chk("ch_out_div1", {8'h0, ch1}, {8'h0, m_vec(0)});
        chk("busy_div1",   {31'h0, busy1}, 32'(m_run[0]));
        chk("done_div1",   {31'h0, done1}, 32'(m_done[0]));
        chk("ch_out_div3", {8'h0, ch3}, {8'h0, m_vec(1)});
        chk("busy_div3",   {31'h0, busy3}, 32'(m_run[1]));
        chk("done_div3",   {31'h0, done3}, 32'(m_done[1]));
      end
    end
  end

  initial begin
    model_reset();
    #12;
    chk("reset_ch", {8'h0, ch1}, 32'h0);
    chk("reset_busy", {31'h0, busy1}, 32'h0);
    chk("reset_done", {31'h0, done1}, 32'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Wrap subtract from zero, then stop
    do_load(24'h000000, 24'h000000);
    do_start(2'b10, 1'b0, 4'd1);
    chk("wsub_busy", {31'h0, busy1}, 32'h1);
    tick();
    chk("wsub_t1", {8'h0, ch1}, 32'hFFFFFF);
    tick();
    chk("wsub_t2", {8'h0, ch1}, 32'hFEFEFE);
    chk("wsub_busy2", {31'h0, busy1}, 32'h1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("wsub_stop_ch", {8'h0, ch1}, 32'hFEFEFE);
    chk("wsub_stop_busy", {31'h0, busy1}, 32'h0);
    chk("wsub_stop_done", {31'h0, done1}, 32'h0);

    // Saturating add (250,252,255) step 4
    do_load(24'hFFFCFA, 24'h000000);
    do_start(2'b01, 1'b1, 4'd4);
    tick();
    chk("sadd_t1", {8'h0, ch1}, 32'hFFFFFE);
    chk("sadd_t1_done", {31'h0, done1}, 32'h0);
    tick();
    chk("sadd_t2", {8'h0, ch1}, 32'hFFFFFF);
    chk("sadd_done", {31'h0, done1}, 32'h1);
    chk("sadd_busy", {31'h0, busy1}, 32'h0);
    tick();
    chk("sadd_done_clr", {31'h0, done1}, 32'h0);

    // Seek (0,200,50) -> (10,190,50) step 4
    do_load(24'h32C800, 24'h32BE0A);
    do_start(2'b11, 1'b0, 4'd4);
    tick();
    chk("seek_t1", {8'h0, ch1}, 32'h32C404);
    tick();
    chk("seek_t2", {8'h0, ch1}, 32'h32C008);
    tick();
    chk("seek_t3", {8'h0, ch1}, 32'h32BE0A);
    chk("seek_done", {31'h0, done1}, 32'h1);
    tick();
    chk("seek_done_clr", {31'h0, done1}, 32'h0);

    // Prescaler on the DIV=3 instance, then load+start abort at k+7
    do_load(24'h000000, 24'h000000);
    do_start(2'b01, 1'b0, 4'd0);
    tick(); chk("pre_k1", {8'h0, ch3}, 32'h000000);
    tick(); chk("pre_k2", {8'h0, ch3}, 32'h000000);
    tick(); chk("pre_k3", {8'h0, ch3}, 32'h010101);
    tick(); chk("pre_k4", {8'h0, ch3}, 32'h010101);
    tick(); chk("pre_k5", {8'h0, ch3}, 32'h010101);
    tick(); chk("pre_k6", {8'h0, ch3}, 32'h020202);
    load = 1'b1; start = 1'b1; ch_in = 24'h090909; target_in = 24'h0;
    tick();
    load = 1'b0; start = 1'b0;
    chk("abort_ch", {8'h0, ch3}, 32'h090909);
    chk("abort_busy", {31'h0, busy3}, 32'h0);
    chk("abort_done", {31'h0, done3}, 32'h0);
    tick();
    chk("abort_idle", {31'h0, busy3}, 32'h0);

    // Seek already at target; start during DONE is ignored
    do_load(24'h050505, 24'h050505);
    do_start(2'b11, 1'b0, 4'd3);
    tick();
    chk("eq_done", {31'h0, done1}, 32'h1);
    chk("eq_ch", {8'h0, ch1}, 32'h050505);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("eq_ign_busy", {31'h0, busy1}, 32'h0);
    chk("eq_ign_done", {31'h0, done1}, 32'h0);

    // Asynchronous reset mid-run with (12,34,56) loaded
    do_load(24'h38220C, 24'h000000);
    do_start(2'b01, 1'b0, 4'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("areset_ch", {8'h0, ch1}, 32'h0);
    chk("areset_busy", {31'h0, busy1}, 32'h0);
    chk("areset_done", {31'h0, done1}, 32'h0);
    model_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      load  = ($urandom_range(15) == 0);
      start = ($urandom_range(3) == 0);
      stop  = ($urandom_range(20) == 0);
      mode  = 2'($urandom_range(3));
      sat   = 1'($urandom_range(1));
      step  = 4'($urandom_range(15));
      ch_in = 24'($urandom);
      if ($urandom_range(1) == 0) target_in = ch_in ^ 24'($urandom_range(63));
      else                        target_in = 24'($urandom);
      tick();
    end
    load = 1'b0; start = 1'b0; stop = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rgb_ramp_engine.md
# rgb_ramp_engine

Parametrised colour-ramp engine for the breadboard RGB controller. It holds CHANNELS colour registers of WIDTH bits each and steps them every DIV clocks. Stepping is add, subtract or seek-to-target, with selectable saturate or wrap behaviour. It sits between the host load path and the PWM stage and drives the per-channel intensity bus. It adds start/stop control, a completion pulse and a tick prescaler.

## Interface

Parameters:
- WIDTH, 8, bits per colour channel
- CHANNELS, 3, number of channels (channel 0 in LSBs: R=0, G=1, B=2)
- STEP_W, 4, width of the step input
- DIV, 1, clocks per update tick (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  capture ch_in/target_in; highest priority
- ch_in  in  CHANNELS*WIDTH  initial channel values
- target_in  in  CHANNELS*WIDTH  seek targets
- start  in  1  begin ramping (sampled in IDLE only)
- stop  in  1  abort ramp (sampled in RUN only)
- mode  in  2  00 hold, 01 add, 10 sub, 11 seek; latched at start
- sat  in  1  1 = clamp at rails, 0 = modulo 2^WIDTH wrap; latched at start
- step  in  STEP_W  step magnitude; latched at start; 0 treated as 1
- ch_out  out  CHANNELS*WIDTH  current channel registers
- busy  out  1  high while in RUN
- done  out  1  one-cycle completion pulse

## Operation

- **States:** IDLE, RUN, DONE.
- **Reset:**
  - State IDLE.
  - ch_out = 0, all target registers = 0.
  - Latched mode/sat/step = 0.
  - Prescaler count = 0, busy = 0, done = 0.
- **load = 1 in any state:**
  - Channel regs ← ch_in; targets ← target_in.
  - Prescaler ← 0; state → IDLE.
  - start and stop are ignored that cycle.
  - A load in RUN aborts the ramp; no done pulse.
- **IDLE:**
  - Registers hold.
  - start = 1 with mode ≠ 00 → RUN: latch mode, sat and step; prescaler ← 0.
  - start = 1 with mode = 00 → stays IDLE.
- **RUN:**
  - Prescaler counts 0..DIV-1. A tick occurs when count = DIV-1; the count then returns to 0.
  - On a tick, every channel updates in parallel:
    - add: ch + step; sat = 1 clamps to 2^WIDTH-1, sat = 0 keeps the low WIDTH bits.
    - sub: ch − step; sat = 1 clamps to 0, sat = 0 wraps modulo 2^WIDTH.
    - seek: ch moves toward its target by min(step, |target − ch|), never overshooting. sat is ignored.
  - Arithmetic uses WIDTH+1-bit intermediates; the step is zero-extended.
- **Completion (evaluated on post-update values at a tick):**
  - add with sat = 1: all channels = 2^WIDTH-1.
  - sub with sat = 1: all channels = 0.
  - seek: all channels = their targets.
  - Wrap add/sub never completes; it runs until stop or load.
  - On completion → DONE.
- **stop = 1 in RUN (no load):**
  - → IDLE at that edge; values hold.
  - A tick coinciding with stop is suppressed.
  - No done pulse.
- **DONE:** done = 1 for exactly this cycle; → IDLE unconditionally (start is ignored in DONE).
- **Seek started with ch already = targets:** completes at the first tick; values are unchanged.

## Timing

- start sampled at edge k → busy = 1 from edge k.
- First update at edge k+DIV; subsequent updates every DIV edges.
- The completing update lands at edge t, and state → DONE at t as well. done = 1 and busy = 0 during the cycle t..t+1; IDLE from t+1.
- ch_out is a direct register output; updates are visible immediately after the tick edge.
- load: ch_out = ch_in one edge later; busy deasserts at the same edge.
- rst_n assertion mid-RUN clears all outputs asynchronously, without waiting for clk. Operation resumes from IDLE after release.

## Test plan

All scenarios use WIDTH=8 and CHANNELS=3, with DIV=1 unless stated.

- **Reset:** drive rst_n = 0 mid-simulation with values (12,34,56) loaded → ch_out = 0, busy = 0 and done = 0 immediately, without waiting for a clk edge.
- **Wrap sub:** load (0,0,0); start mode = 10, sat = 0, step = 1 → first tick gives (255,255,255); busy stays 1; done never pulses; stop returns to IDLE holding (254,254,254) after the second tick.
- **Saturating add:** load (250,252,255); start mode = 01, sat = 1, step = 4 → tick1 (254,255,255), tick2 (255,255,255); done pulses one cycle; busy = 0.
- **Seek:** load ch (0,200,50), targets (10,190,50); step = 4 → ticks give (4,196,50), (8,192,50), (10,190,50); done pulses once.
- **Prescaler and load abort:** DIV = 3, load (0,0,0), start add with step = 0 (treated as 1) → ch_out changes at edges k+3 and k+6 only. At edge k+7, load = 1 with ch_in (9,9,9) and start = 1 together → ch_out = (9,9,9); state IDLE; no done.
- **Boundary:** start a seek with ch = targets = (5,5,5) → done at the first tick, values unchanged. Assert start during the DONE cycle → ignored; the engine returns to IDLE.
